chip8_mem_arbiter: RTL and testbench
====================================

# chip8_mem_arbiter

Shares the single chip8_ram (one read port, one write port, 12-bit address, 8-bit data, registered read) among three masters: the video scanout (framebuffer reads), the ppu (sprite reads plus framebuffer read-modify-write) and the CPU (fetch, load, store, clear-screen). It sits between those masters and chip8_ram. It is the only block driving the RAM ports. It grants one read and one write per cycle, returns read data with a per-master valid, forwards same-cycle write data, and guards CPU starvation and ppu framebuffer atomicity.

## Interface
- FB_BASE, 12'h100: framebuffer base address; 256 bytes, 8 bytes per 64-pixel row.
- CPU_STARVE_LIMIT, 4: consecutive denied CPU read cycles before the CPU is promoted above the ppu.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- vid_rd_req / vid_rd_addr  in  1 / 8  scanout read request; the address is an offset into the framebuffer.
- ppu_rd_req / ppu_rd_addr  in  1 / 12  ppu read request.
- cpu_rd_req / cpu_rd_addr  in  1 / 12  CPU read request.
- vid_rd_gnt, ppu_rd_gnt, cpu_rd_gnt  out  1 each  read grant, same cycle as the request.
- vid_rd_valid, ppu_rd_valid, cpu_rd_valid  out  1 each  rd_data belongs to this master.
- rd_data  out  8  shared read return bus.
- ppu_wr_req / ppu_wr_addr / ppu_wr_data  in  1 / 12 / 8  ppu write request.
- cpu_wr_req / cpu_wr_addr / cpu_wr_data  in  1 / 12 / 8  CPU write request.
- ppu_wr_gnt, cpu_wr_gnt  out  1 each  write grant; the write commits at the end of this cycle.
- ppu_lock  in  1  ppu draw in progress; blocks CPU writes to the framebuffer window.
- mem_read_address  out  12  to RAM read port.
- mem_read_data  in  8  RAM q; valid one cycle after the address.
- mem_write_address / mem_write_data / mem_write_enable  out  12 / 8 / 1  to RAM write port.

## Operation
- Handshake: a master holds req and addr (and data) stable until it sees gnt. It may present a new request in the cycle after gnt, so back-to-back accesses run at one per cycle.
- Read priority: video > ppu > CPU.
- Starvation: starve_cnt (3 bits) increments each cycle cpu_rd_req=1 && !cpu_rd_gnt. It clears on cpu_rd_gnt or when cpu_rd_req=0.
  - When starve_cnt == CPU_STARVE_LIMIT, the order becomes video > CPU > ppu for that cycle.
  - Video is never overridden.
- Video address: mem_read_address = FB_BASE + vid_rd_addr, added in 12 bits; FB_BASE+0xFF must not wrap past 0xFFF.
- Write priority: ppu > CPU. cpu_wr_gnt is forced 0 while ppu_lock=1 and cpu_wr_addr is in [FB_BASE, FB_BASE+255]. CPU writes outside that window proceed normally.
- mem_write_enable = ppu_wr_gnt | cpu_wr_gnt.
- Idle outputs: with no write grant, mem_write_address and mem_write_data hold their last values. With no read grant, mem_read_address holds its last value.
- Return tag: a 2-bit register holds the granted read master (none/vid/ppu/cpu). It drives exactly one *_rd_valid in the following cycle.
- Bypass: if a read and a write are granted to the same address in one cycle, the write data is registered. rd_data returns that new data next cycle instead of mem_read_data.
- Reads and writes from the same master in the same cycle are legal and independent. The ppu RMW (read then write the same byte) therefore completes in 2 cycles when uncontended.

## Timing
- Grants: combinational from requests, ppu_lock and the registered starve_cnt. Request-to-grant latency is 0 cycles.
- Read data: rd_data and the matching valid are asserted exactly 1 cycle after the grant, for 1 cycle.
- Reset values (reset=0): all *_rd_valid=0, mem_write_enable=0, starve_cnt=0, tag=none, bypass flag=0, rd_data=0, mem_read_address=0, mem_write_address=0, mem_write_data=0.
- During reset all gnt outputs are forced 0.
- Reset mid-operation: an in-flight return is dropped and no valid is asserted after reset deasserts.
- First grant after deassertion: possible in the first rising edge cycle with reset=1.

## Structure
- Package chip8_mem_pkg holds:
  - ADDR_W=12, DATA_W=8, FB_BYTES=256, FB_BASE default;
  - the master id enum MST_NONE=0, MST_VID=1, MST_PPU=2, MST_CPU=3 (2 bits).
- Sub-module chip8_prio_arb3: 3-input fixed-priority arbiter with a "swap inputs 1 and 2" control.
  - Instantiated once for the read port with the starvation swap.
  - Instantiated once for the write port with the video input tied 0.
- Tag register, bypass register, starve counter and address muxes live in the top level.

## Test plan
- Video vs ppu vs CPU reads all requesting in one cycle, vid_rd_addr=8'h41 → vid_rd_gnt=1, mem_read_address=12'h141, vid_rd_valid next cycle with rd_data=mem[0x141]. The other grants stay 0.
- ppu and CPU reads held continuously → ppu granted for cycles 1–4. On cycle 5 (starve_cnt=4) cpu_rd_gnt=1 and starve_cnt clears to 0.
- ppu_lock=1, CPU writes 8'hAA to 12'h150 and 8'h55 to 12'h300 → no write to 0x150 while locked; the 0x300 write commits immediately. After lock drops, the 0x150 write is granted and mem[0x150]=AA.
- ppu reads 12'h142 while the CPU writes 8'hF0 to 12'h142 in the same cycle → ppu_rd_valid next cycle with rd_data=8'hF0 (bypass).
- ppu RMW at 12'h141 (read 8'h0F, write 8'h0F^8'hFF) back-to-back → mem[0x141]=8'hF0 two cycles after the read request.
- reset asserted the cycle after cpu_rd_gnt → cpu_rd_valid never pulses, all outputs are at reset values, and grants resume the first cycle after release.

Source files
------------

// File: rtl/chip8_mem_arbiter_pkg.sv
// Shared constants, master ids and address helpers for the chip8 RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package chip8_mem_pkg;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 8;
    localparam int FB_BYTES = 256;
    localparam int FB_AW    = $clog2(FB_BYTES);
    localparam int STARVE_W = 3;

    localparam logic [ADDR_W-1:0] FB_BASE_DFLT          = 12'h100;
    localparam int                CPU_STARVE_LIMIT_DFLT = 4;

    // Identifies which read master owns the return slot one cycle after grant.
    typedef enum logic [1:0] {
        MST_NONE = 2'd0,
        MST_VID  = 2'd1,
        MST_PPU  = 2'd2,
        MST_CPU  = 2'd3
    } mst_e;

    // True when addr falls inside the framebuffer window starting at base.
    function automatic logic in_fb_window(input logic [ADDR_W-1:0] addr,
                                          input logic [ADDR_W-1:0] base);
        return (addr >= base) && (addr <= base + ADDR_W'(FB_BYTES - 1));
    endfunction

endpackage

// File: rtl/chip8_mem_arbiter_if.sv
// Bundle of master request/grant/return signals plus the chip8_ram port pins.
// Latency: n/a (wiring only).
// Backpressure: req/addr/data held by the master until its gnt is seen.
interface chip8_mem_arbiter_if;
    import chip8_mem_pkg::*;

    logic                 vid_rd_req;
    logic [FB_AW-1:0]     vid_rd_addr;
    logic                 ppu_rd_req;
    logic [ADDR_W-1:0]    ppu_rd_addr;
    logic                 cpu_rd_req;
    logic [ADDR_W-1:0]    cpu_rd_addr;
    logic                 vid_rd_gnt;
    logic                 ppu_rd_gnt;
    logic                 cpu_rd_gnt;
    logic                 vid_rd_valid;
    logic                 ppu_rd_valid;
    logic                 cpu_rd_valid;
    logic [DATA_W-1:0]    rd_data;

    logic                 ppu_wr_req;
    logic [ADDR_W-1:0]    ppu_wr_addr;
    logic [DATA_W-1:0]    ppu_wr_data;
    logic                 cpu_wr_req;
    logic [ADDR_W-1:0]    cpu_wr_addr;
    logic [DATA_W-1:0]    cpu_wr_data;
    logic                 ppu_wr_gnt;
    logic                 cpu_wr_gnt;
    logic                 ppu_lock;

    logic [ADDR_W-1:0]    mem_read_address;
    logic [DATA_W-1:0]    mem_read_data;
    logic [ADDR_W-1:0]    mem_write_address;
    logic [DATA_W-1:0]    mem_write_data;
    logic                 mem_write_enable;

    // Arbiter side: takes requests and RAM q, drives grants, returns and RAM pins.
    modport slave (
        input  vid_rd_req, vid_rd_addr, ppu_rd_req, ppu_rd_addr, cpu_rd_req, cpu_rd_addr,
        input  ppu_wr_req, ppu_wr_addr, ppu_wr_data, cpu_wr_req, cpu_wr_addr, cpu_wr_data,
        input  ppu_lock, mem_read_data,
        output vid_rd_gnt, ppu_rd_gnt, cpu_rd_gnt,
        output vid_rd_valid, ppu_rd_valid, cpu_rd_valid, rd_data,
        output ppu_wr_gnt, cpu_wr_gnt,
        output mem_read_address, mem_write_address, mem_write_data, mem_write_enable
    );

    // Environment side: the masters and the RAM.
    modport master (
        output vid_rd_req, vid_rd_addr, ppu_rd_req, ppu_rd_addr, cpu_rd_req, cpu_rd_addr,
        output ppu_wr_req, ppu_wr_addr, ppu_wr_data, cpu_wr_req, cpu_wr_addr, cpu_wr_data,
        output ppu_lock, mem_read_data,
        input  vid_rd_gnt, ppu_rd_gnt, cpu_rd_gnt,
        input  vid_rd_valid, ppu_rd_valid, cpu_rd_valid, rd_data,
        input  ppu_wr_gnt, cpu_wr_gnt,
        input  mem_read_address, mem_write_address, mem_write_data, mem_write_enable
    );

endinterface

// File: rtl/chip8_prio_arb3.sv
// Three-input fixed-priority arbiter; input 0 always wins, swap_12 flips 1 vs 2.
// Latency: 0 cycles, purely combinational.
// Backpressure: losers simply see gnt=0 and keep requesting.
module chip8_prio_arb3 (
    input  logic [2:0] req,
    input  logic       swap_12,
    output logic [2:0] gnt
);

    // One-hot grant; input 0 is never overridden by the swap.
    always_comb begin
        gnt = 3'b000;
        if (req[0]) begin
            gnt[0] = 1'b1;
        end else if (swap_12) begin
            if (req[2]) begin
                gnt[2] = 1'b1;
            end else if (req[1]) begin
                gnt[1] = 1'b1;
            end
        end else begin
            if (req[1]) begin
                gnt[1] = 1'b1;
            end else if (req[2]) begin
                gnt[2] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chip8_mem_arbiter.sv
// Shares chip8_ram between video, ppu and CPU: one read and one write grant per cycle.
// Latency: grant same cycle as request; read data + per-master valid one cycle later.
// Backpressure: denied masters hold req; CPU promoted over ppu after a starvation run.
module chip8_mem_arbiter
    import chip8_mem_pkg::*;
#(
    parameter logic [ADDR_W-1:0] FB_BASE          = FB_BASE_DFLT,
    parameter int                CPU_STARVE_LIMIT = CPU_STARVE_LIMIT_DFLT
) (
    input  logic                clk,
    input  logic                reset,
    chip8_mem_arbiter_if.slave  bus
);

    logic [2:0]          rd_req;
    logic [2:0]          rd_gnt;
    logic [2:0]          wr_req;
    logic [2:0]          wr_gnt;
    logic                rd_any;
    logic                wr_any;
    logic                starve_swap;
    logic                cpu_fb_blocked;

    logic [STARVE_W-1:0] starve_cnt_d, starve_cnt_q;
    mst_e                tag_d, tag_q;
    logic                bypass_d, bypass_q;
    logic [ADDR_W-1:0]   raddr_d, raddr_q;
    logic [ADDR_W-1:0]   waddr_d, waddr_q;
    logic [DATA_W-1:0]   wdat_d, wdat_q;

    // Requests are masked while reset is low so every grant reads 0 during reset.
    assign rd_req = {bus.cpu_rd_req, bus.ppu_rd_req, bus.vid_rd_req} & {3{reset}};

    // CPU writes into the framebuffer must not tear a ppu draw in progress.
    assign cpu_fb_blocked = bus.ppu_lock && in_fb_window(bus.cpu_wr_addr, FB_BASE);
    assign wr_req = {bus.cpu_wr_req && !cpu_fb_blocked, bus.ppu_wr_req, 1'b0} & {3{reset}};

    assign starve_swap = (starve_cnt_q == STARVE_W'(CPU_STARVE_LIMIT));

    chip8_prio_arb3 u_rd_arb (
        .req     (rd_req),
        .swap_12 (starve_swap),
        .gnt     (rd_gnt)
    );

    chip8_prio_arb3 u_wr_arb (
        .req     (wr_req),
        .swap_12 (1'b0),
        .gnt     (wr_gnt)
    );

    assign rd_any = |rd_gnt;
    assign wr_any = |wr_gnt;

    // Read address mux and return tag; address holds its last value when idle.
    always_comb begin
        raddr_d = raddr_q;
        tag_d   = MST_NONE;
        if (rd_gnt[0]) begin
            raddr_d = FB_BASE + ADDR_W'(bus.vid_rd_addr);
            tag_d   = MST_VID;
        end else if (rd_gnt[1]) begin
            raddr_d = bus.ppu_rd_addr;
            tag_d   = MST_PPU;
        end else if (rd_gnt[2]) begin
            raddr_d = bus.cpu_rd_addr;
            tag_d   = MST_CPU;
        end
    end

    // Write address/data mux; both hold their last values when no write is granted.
    always_comb begin
        waddr_d = waddr_q;
        wdat_d  = wdat_q;
        if (wr_gnt[1]) begin
            waddr_d = bus.ppu_wr_addr;
            wdat_d  = bus.ppu_wr_data;
        end else if (wr_gnt[2]) begin
            waddr_d = bus.cpu_wr_addr;
            wdat_d  = bus.cpu_wr_data;
        end
    end

    // RAM reads the old byte on a same-address collision, so remember to return the
    // new byte instead; wdat_q already holds it in the following cycle.
    always_comb begin
        bypass_d = rd_any && wr_any && (raddr_d == waddr_d);
    end

    // Count consecutive cycles the CPU read is refused, saturating at the counter max.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.cpu_rd_req || rd_gnt[2]) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != {STARVE_W{1'b1}}) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // State registers; async reset drops any in-flight return.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= '0;
            tag_q        <= MST_NONE;
            bypass_q     <= 1'b0;
            raddr_q      <= '0;
            waddr_q      <= '0;
            wdat_q       <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            tag_q        <= tag_d;
            bypass_q     <= bypass_d;
            raddr_q      <= raddr_d;
            waddr_q      <= waddr_d;
            wdat_q       <= wdat_d;
        end
    end

    assign bus.vid_rd_gnt = rd_gnt[0];
    assign bus.ppu_rd_gnt = rd_gnt[1];
    assign bus.cpu_rd_gnt = rd_gnt[2];
    assign bus.ppu_wr_gnt = wr_gnt[1];
    assign bus.cpu_wr_gnt = wr_gnt[2];

    assign bus.mem_read_address  = raddr_d;
    assign bus.mem_write_address = waddr_d;
    assign bus.mem_write_data    = wdat_d;
    assign bus.mem_write_enable  = wr_any;

    assign bus.vid_rd_valid = (tag_q == MST_VID);
    assign bus.ppu_rd_valid = (tag_q == MST_PPU);
    assign bus.cpu_rd_valid = (tag_q == MST_CPU);

    // Return bus is quiet (0) whenever no master owns the slot, including in reset.
    assign bus.rd_data = (tag_q == MST_NONE) ? '0 :
                         (bypass_q ? wdat_q : bus.mem_read_data);

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Bench for chip8_mem_arbiter: directed scenarios plus random traffic vs a reference model.
// Latency: checks grants in the request cycle and returns one cycle later.
// Backpressure: bench masters hold requests until granted.
module tb_chip8_mem_arbiter;

    logic clk;
    logic reset;

    chip8_mem_arbiter_if bus ();

    chip8_mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: registered read of the old contents, write at end of cycle.
    logic [7:0] ram [0:4095];
    logic [7:0] ram_q;
    always @(posedge clk) begin
        if (bus.mem_write_enable) ram[bus.mem_write_address] <= bus.mem_write_data;
        ram_q <= ram[bus.mem_read_address];
    end
    assign bus.mem_read_data = ram_q;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state: 0 none, 1 video, 2 ppu, 3 cpu.
    logic [7:0]  ref_mem [0:4095];
    int          starve;
    int          pend_mst;
    logic [7:0]  pend_dat;
    logic [11:0] last_ra, last_wa;
    logic [7:0]  last_wd;
    logic        g_vr, g_pr, g_cr, g_pw, g_cw;

    function automatic logic [7:0] init_byte(input int a);
        return 8'((a * 37 + 11) & 255);
    endfunction

    task automatic model_check();
        logic e_vg, e_pg, e_cg, e_pwg, e_cwg, e_we, fbw;
        int   exp_mst;
        e_vg = 0; e_pg = 0; e_cg = 0; e_pwg = 0; e_cwg = 0;
        exp_mst = reset ? pend_mst : 0;
        chk("rd_valid", {bus.vid_rd_valid, bus.ppu_rd_valid, bus.cpu_rd_valid},
            {exp_mst == 1, exp_mst == 2, exp_mst == 3});
        if (exp_mst != 0) chk("rd_data", bus.rd_data, pend_dat);
        else if (!reset) chk("rd_data_reset", bus.rd_data, 0);
        if (reset) begin
            if (bus.vid_rd_req) e_vg = 1;
            else if (bus.cpu_rd_req && (starve == 4 || !bus.ppu_rd_req)) e_cg = 1;
            else if (bus.ppu_rd_req) e_pg = 1;
            fbw   = (bus.cpu_wr_addr >= 12'h100) && (bus.cpu_wr_addr <= 12'h1FF);
            e_pwg = bus.ppu_wr_req;
            e_cwg = bus.cpu_wr_req && !bus.ppu_wr_req && !(bus.ppu_lock && fbw);
        end
        chk("rd_gnt", {bus.vid_rd_gnt, bus.ppu_rd_gnt, bus.cpu_rd_gnt}, {e_vg, e_pg, e_cg});
        chk("wr_gnt", {bus.ppu_wr_gnt, bus.cpu_wr_gnt}, {e_pwg, e_cwg});
        if (!reset) begin
            last_ra = 0; last_wa = 0; last_wd = 0;
        end
        if (e_vg)      last_ra = 12'h100 + {4'h0, bus.vid_rd_addr};
        else if (e_pg) last_ra = bus.ppu_rd_addr;
        else if (e_cg) last_ra = bus.cpu_rd_addr;
        chk("mem_read_address", bus.mem_read_address, last_ra);
        e_we = e_pwg || e_cwg;
        if (e_pwg) begin
            last_wa = bus.ppu_wr_addr; last_wd = bus.ppu_wr_data;
        end else if (e_cwg) begin
            last_wa = bus.cpu_wr_addr; last_wd = bus.cpu_wr_data;
        end
        chk("mem_write_enable", bus.mem_write_enable, e_we);
        chk("mem_write_address", bus.mem_write_address, last_wa);
        chk("mem_write_data", bus.mem_write_data, last_wd);
        pend_mst = e_vg ? 1 : e_pg ? 2 : e_cg ? 3 : 0;
        pend_dat = (e_we && last_wa == last_ra) ? last_wd : ref_mem[last_ra];
        if (e_we) ref_mem[last_wa] = last_wd;
        if (!reset || !bus.cpu_rd_req || e_cg) starve = 0;
        else if (starve < 7) starve++;
        g_vr = e_vg; g_pr = e_pg; g_cr = e_cg; g_pw = e_pwg; g_cw = e_cwg;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic end_cycle();
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        at_neg();
        end_cycle();
    endtask

    task automatic idle_inputs();
        bus.vid_rd_req = 0; bus.ppu_rd_req = 0; bus.cpu_rd_req = 0;
        bus.ppu_wr_req = 0; bus.cpu_wr_req = 0; bus.ppu_lock = 0;
    endtask

    function automatic logic [11:0] rnd_addr();
        case ($urandom_range(0, 2))
            0:       return 12'h140 + 12'($urandom_range(0, 7));
            1:       return 12'h100 + 12'($urandom_range(0, 255));
            default: return 12'($urandom);
        endcase
    endfunction

    initial begin
        for (int a = 0; a < 4096; a++) begin
            ram[a]     = init_byte(a);
            ref_mem[a] = init_byte(a);
        end
        starve = 0; pend_mst = 0; pend_dat = 0;
        last_ra = 0; last_wa = 0; last_wd = 0;
        reset = 0;
        idle_inputs();
        bus.vid_rd_addr = 0; bus.ppu_rd_addr = 0; bus.cpu_rd_addr = 0;
        bus.ppu_wr_addr = 0; bus.ppu_wr_data = 0; bus.cpu_wr_addr = 0; bus.cpu_wr_data = 0;

        // Reset values, with requests present to show grants forced low.
        @(posedge clk); #1;
        bus.cpu_rd_req = 1; bus.cpu_wr_req = 1; bus.cpu_wr_addr = 12'h300;
        tick();
        idle_inputs();
        tick();
        reset = 1;

        // Three-way read contention, video wins with framebuffer-relative address.
        bus.vid_rd_req = 1; bus.vid_rd_addr = 8'h41;
        bus.ppu_rd_req = 1; bus.ppu_rd_addr = 12'h200;
        bus.cpu_rd_req = 1; bus.cpu_rd_addr = 12'h300;
        at_neg();
        chk("vid_first_gnt", {bus.vid_rd_gnt, bus.ppu_rd_gnt, bus.cpu_rd_gnt}, 3'b100);
        chk("vid_addr_141", bus.mem_read_address, 12'h141);
        end_cycle();
        idle_inputs();
        at_neg();
        chk("vid_valid", bus.vid_rd_valid, 1);
        chk("vid_data", bus.rd_data, init_byte(12'h141));
        end_cycle();

        // Starvation: ppu wins four cycles, CPU promoted on the fifth.
        bus.ppu_rd_req = 1; bus.ppu_rd_addr = 12'h200;
        bus.cpu_rd_req = 1; bus.cpu_rd_addr = 12'h300;
        for (int i = 1; i <= 6; i++) begin
            at_neg();
            chk($sformatf("starve_ppu_c%0d", i), bus.ppu_rd_gnt, (i != 5));
            chk($sformatf("starve_cpu_c%0d", i), bus.cpu_rd_gnt, (i == 5));
            end_cycle();
        end
        idle_inputs();

        // ppu_lock blocks CPU framebuffer writes only.
        bus.ppu_lock = 1;
        bus.cpu_wr_req = 1; bus.cpu_wr_addr = 12'h300; bus.cpu_wr_data = 8'h55;
        at_neg();
        chk("lock_outside_gnt", bus.cpu_wr_gnt, 1);
        end_cycle();
        bus.cpu_wr_addr = 12'h150; bus.cpu_wr_data = 8'hAA;
        for (int i = 0; i < 2; i++) begin
            at_neg();
            chk("lock_fb_blocked", {bus.cpu_wr_gnt, bus.mem_write_enable}, 2'b00);
            end_cycle();
        end
        bus.ppu_lock = 0;
        at_neg();
        chk("unlock_fb_gnt", bus.cpu_wr_gnt, 1);
        chk("unlock_fb_addr", bus.mem_write_address, 12'h150);
        end_cycle();
        bus.cpu_wr_req = 0;
        bus.cpu_rd_req = 1; bus.cpu_rd_addr = 12'h150;
        tick();
        bus.cpu_rd_addr = 12'h300;
        at_neg();
        chk("readback_150", bus.rd_data, 8'hAA);
        end_cycle();
        bus.cpu_rd_req = 0;
        at_neg();
        chk("readback_300", bus.rd_data, 8'h55);
        end_cycle();

        // Same-cycle read/write to one address returns the new byte.
        bus.ppu_rd_req = 1; bus.ppu_rd_addr = 12'h142;
        bus.cpu_wr_req = 1; bus.cpu_wr_addr = 12'h142; bus.cpu_wr_data = 8'hF0;
        at_neg();
        chk("bypass_gnts", {bus.ppu_rd_gnt, bus.cpu_wr_gnt}, 2'b11);
        end_cycle();
        idle_inputs();
        at_neg();
        chk("bypass_valid", bus.ppu_rd_valid, 1);
        chk("bypass_data", bus.rd_data, 8'hF0);
        end_cycle();

        // ppu read-modify-write at 0x141.
        bus.cpu_wr_req = 1; bus.cpu_wr_addr = 12'h141; bus.cpu_wr_data = 8'h0F;
        tick();
        bus.cpu_wr_req = 0;
        bus.ppu_rd_req = 1; bus.ppu_rd_addr = 12'h141;
        tick();
        bus.ppu_rd_req = 0;
        bus.ppu_wr_req = 1; bus.ppu_wr_addr = 12'h141; bus.ppu_wr_data = 8'h0F ^ 8'hFF;
        at_neg();
        chk("rmw_read_data", bus.rd_data, 8'h0F);
        chk("rmw_wr_gnt", bus.ppu_wr_gnt, 1);
        end_cycle();
        bus.ppu_wr_req = 0;
        at_neg();
        chk("rmw_ram", ram[12'h141], 8'hF0);
        end_cycle();

        // Reset right after a CPU grant drops the return.
        bus.cpu_rd_req = 1; bus.cpu_rd_addr = 12'h300;
        at_neg();
        chk("pre_reset_gnt", bus.cpu_rd_gnt, 1);
        end_cycle();
        reset = 0;
        at_neg();
        chk("reset_no_valid", bus.cpu_rd_valid, 0);
        chk("reset_gnt_low", bus.cpu_rd_gnt, 0);
        chk("reset_rd_data", bus.rd_data, 0);
        end_cycle();
        reset = 1;
        at_neg();
        chk("post_reset_gnt", bus.cpu_rd_gnt, 1);
        chk("post_reset_no_valid", bus.cpu_rd_valid, 0);
        end_cycle();
        bus.cpu_rd_req = 0;
        at_neg();
        chk("post_reset_data", bus.rd_data, 8'h55);
        end_cycle();

        // Random traffic; masters hold their request until granted.
        g_vr = 0; g_pr = 0; g_cr = 0; g_pw = 0; g_cw = 0;
        for (int c = 0; c < 2000; c++) begin
            if (!bus.vid_rd_req || g_vr) begin
                bus.vid_rd_req = ($urandom_range(0, 2) == 0);
                bus.vid_rd_addr = 8'($urandom);
            end
            if (!bus.ppu_rd_req || g_pr) begin
                bus.ppu_rd_req = ($urandom_range(0, 1) == 0);
                bus.ppu_rd_addr = rnd_addr();
            end
            if (!bus.cpu_rd_req || g_cr) begin
                bus.cpu_rd_req = ($urandom_range(0, 1) == 0);
                bus.cpu_rd_addr = rnd_addr();
            end
            if (!bus.ppu_wr_req || g_pw) begin
                bus.ppu_wr_req = ($urandom_range(0, 2) == 0);
                bus.ppu_wr_addr = rnd_addr();
                bus.ppu_wr_data = 8'($urandom);
            end
            if (!bus.cpu_wr_req || g_cw) begin
                bus.cpu_wr_req = ($urandom_range(0, 1) == 0);
                bus.cpu_wr_addr = rnd_addr();
                bus.cpu_wr_data = 8'($urandom);
            end
            if ($urandom_range(0, 3) == 0) bus.ppu_lock = !bus.ppu_lock;
            if (c == 1500) reset = 0;
            if (c == 1502) reset = 1;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
